// File: rtl/regfile_sb_if.sv
// Bus bundle between decode/writeback and the scoreboarded register file.
// The master side drives addresses, write/lock requests and clr; the slave returns data and status.
interface regfile_sb_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             busy1;
  logic             busy2;
  logic             wr;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic             lock;
  logic [AW-1:0]    la;
  logic             clr;
  logic             ready;
  logic             lock_err;

  modport master (
    output ra1, ra2, wr, wa, wd, lock, la, clr,
    input  rd1, rd2, busy1, busy2, ready, lock_err
  );

  modport slave (
    input  ra1, ra2, wr, wa, wd, lock, la, clr,
    output rd1, rd2, busy1, busy2, ready, lock_err
  );
endinterface

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-first bypass, pending-write scoreboard
// and a one-entry-per-cycle clear sweep that runs after reset or on clr.
module regfile_sb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam int          NRD  = 2;

  typedef enum logic [0:0] {ST_CLEAR, ST_IDLE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic [DEPTH-1:0]   busy_q, busy_d;
  logic               lock_err_q, lock_err_d;

  // Storage is deliberately left out of reset; the sweep zeroes it.
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               mem_we;
  logic [AW-1:0]      mem_wa;
  logic [WIDTH-1:0]   mem_wd;

  logic               idle;
  logic               wr_hits_la;

  assign idle       = (state_q == ST_IDLE);
  assign wr_hits_la = bus.wr && (bus.wa == bus.la);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    lock_err_d = 1'b0;
    mem_we     = 1'b0;
    mem_wa     = bus.wa;
    mem_wd     = bus.wd;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        busy_d = '0;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end

      ST_IDLE: begin
        if (bus.clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = '0;
        end else begin
          if (bus.wr) begin
            mem_we            = 1'b1;
            busy_d[bus.wa]    = 1'b0;
          end
          // Applied after the write so a same-address lock keeps the register pending.
          if (bus.lock) begin
            busy_d[bus.la] = 1'b1;
            lock_err_d     = busy_q[bus.la] && !wr_hits_la;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        busy_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      busy_q     <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      lock_err_q <= lock_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  logic [NRD-1:0][AW-1:0]    ra_v;
  logic [NRD-1:0][WIDTH-1:0] rd_v;
  logic [NRD-1:0]            busy_v;

  assign ra_v[0] = bus.ra1;
  assign ra_v[1] = bus.ra2;

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic hit;
      assign hit        = bus.wr && (bus.wa == ra_v[gi]);
      // Bypassed write data counts as available, so it also masks the busy bit.
      assign rd_v[gi]   = idle ? (hit ? bus.wd : mem_q[ra_v[gi]]) : '0;
      assign busy_v[gi] = idle && busy_q[ra_v[gi]] && !hit;
    end
  endgenerate

  assign bus.rd1      = rd_v[0];
  assign bus.rd2      = rd_v[1];
  assign bus.busy1    = busy_v[0];
  assign bus.busy2    = busy_v[1];
  assign bus.ready    = idle;
  assign bus.lock_err = lock_err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed test of regfile_sb: 32x4 instance for the main sequence, 16x8 for
// the parametrised sweep length and asynchronous reset in the middle of a sweep.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(32), .DEPTH(4)) ba ();
  regfile_sb_if #(.WIDTH(16), .DEPTH(8)) bb ();

  regfile_sb #(.WIDTH(32), .DEPTH(4)) dut_a (.clk(clk), .rst_n(rst_n_a), .bus(ba.slave));
  regfile_sb #(.WIDTH(16), .DEPTH(8)) dut_b (.clk(clk), .rst_n(rst_n_b), .bus(bb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ba.ra1 = '0; ba.ra2 = '0; ba.wr = 1'b0; ba.wa = '0; ba.wd = '0;
    ba.lock = 1'b0; ba.la = '0; ba.clr = 1'b0;
    bb.ra1 = '0; bb.ra2 = '0; bb.wr = 1'b0; bb.wa = '0; bb.wd = '0;
    bb.lock = 1'b0; bb.la = '0; bb.clr = 1'b0;

    // ---------------- reset values ----------------
    #2;
    chk("a_rst_ready", 32'(ba.ready), 32'h0);
    chk("a_rst_lock_err", 32'(ba.lock_err), 32'h0);
    chk("a_rst_busy1", 32'(ba.busy1), 32'h0);
    chk("a_rst_rd1", ba.rd1, 32'h0);
    tick();
    rst_n_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("a_sweep0_ready_e%0d", i), 32'(ba.ready), 32'(i == 4));
    end

    // ---------------- preload, reset, sweep ----------------
    $display("step: preload 0xDEADBEEF then reset sweep");
    for (int i = 0; i < 4; i++) begin
      ba.wr = 1'b1; ba.wa = 2'(i); ba.wd = 32'hDEADBEEF;
      tick();
    end
    ba.wr = 1'b0;
    ba.ra1 = 2'd0; ba.ra2 = 2'd3;
    #1;
    chk("a_preload_rd1", ba.rd1, 32'hDEADBEEF);
    chk("a_preload_rd2", ba.rd2, 32'hDEADBEEF);
    rst_n_a = 1'b0;
    #1;
    chk("a_rst2_ready", 32'(ba.ready), 32'h0);
    chk("a_rst2_rd1", ba.rd1, 32'h0);
    tick();
    rst_n_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("a_sweep_ready_e%0d", i), 32'(ba.ready), 32'(i == 4));
    end
    for (int i = 0; i < 4; i++) begin
      ba.ra1 = 2'(i); ba.ra2 = 2'(3 - i);
      #1;
      chk($sformatf("a_zero_rd1_r%0d", i), ba.rd1, 32'h0);
      chk($sformatf("a_zero_rd2_r%0d", 3 - i), ba.rd2, 32'h0);
    end

    // ---------------- write / bypass ----------------
    $display("step: write reg2 with bypass");
    ba.wr = 1'b1; ba.wa = 2'd2; ba.wd = 32'hA5A5A5A5; ba.ra1 = 2'd2; ba.ra2 = 2'd3;
    #1;
    chk("a_bypass_rd1", ba.rd1, 32'hA5A5A5A5);
    chk("a_bypass_rd2", ba.rd2, 32'h0);
    tick();
    ba.wr = 1'b0;
    #1;
    chk("a_after_wr_rd1", ba.rd1, 32'hA5A5A5A5);

    // ---------------- scoreboard ----------------
    $display("step: lock reg1, then write it");
    ba.lock = 1'b1; ba.la = 2'd1; ba.ra1 = 2'd1;
    #1;
    chk("a_busy1_before_edge", 32'(ba.busy1), 32'h0);
    tick();
    ba.lock = 1'b0;
    #1;
    chk("a_busy1_locked", 32'(ba.busy1), 32'h1);
    chk("a_lock_err_first", 32'(ba.lock_err), 32'h0);
    ba.wr = 1'b1; ba.wa = 2'd1; ba.wd = 32'h7;
    #1;
    chk("a_busy1_wr_cycle", 32'(ba.busy1), 32'h0);
    chk("a_rd1_wr_cycle", ba.rd1, 32'h7);
    tick();
    ba.wr = 1'b0;
    #1;
    chk("a_busy1_after_wr", 32'(ba.busy1), 32'h0);
    chk("a_rd1_after_wr", ba.rd1, 32'h7);

    // ---------------- lock conflicts ----------------
    $display("step: double lock on reg3");
    ba.lock = 1'b1; ba.la = 2'd3; ba.ra2 = 2'd3;
    tick();
    chk("a_lock3_err_e1", 32'(ba.lock_err), 32'h0);
    chk("a_lock3_busy2", 32'(ba.busy2), 32'h1);
    tick();
    ba.lock = 1'b0;
    #1;
    chk("a_lock3_err_e2", 32'(ba.lock_err), 32'h1);
    tick();
    chk("a_lock3_err_e3", 32'(ba.lock_err), 32'h0);
    $display("step: lock and write reg3 together while busy");
    ba.lock = 1'b1; ba.la = 2'd3; ba.wr = 1'b1; ba.wa = 2'd3; ba.wd = 32'h33;
    #1;
    chk("a_lockwr_busy2_masked", 32'(ba.busy2), 32'h0);
    tick();
    ba.lock = 1'b0; ba.wr = 1'b0;
    #1;
    chk("a_lockwr_err", 32'(ba.lock_err), 32'h0);
    chk("a_lockwr_busy2", 32'(ba.busy2), 32'h1);
    chk("a_lockwr_rd2", ba.rd2, 32'h33);

    // ---------------- clr mid-operation ----------------
    $display("step: clr with concurrent write to reg0");
    ba.wr = 1'b1; ba.wa = 2'd0; ba.wd = 32'h55;
    tick();
    ba.wr = 1'b0; ba.lock = 1'b1; ba.la = 2'd0;
    tick();
    ba.lock = 1'b0; ba.ra1 = 2'd0; ba.ra2 = 2'd3;
    #1;
    chk("a_preclr_busy1", 32'(ba.busy1), 32'h1);
    chk("a_preclr_rd1", ba.rd1, 32'h55);
    ba.clr = 1'b1; ba.wr = 1'b1; ba.wa = 2'd0; ba.wd = 32'h99;
    tick();
    ba.clr = 1'b0; ba.wr = 1'b0;
    #1;
    chk("a_clr_ready", 32'(ba.ready), 32'h0);
    chk("a_clr_busy1", 32'(ba.busy1), 32'h0);
    chk("a_clr_rd1", ba.rd1, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("a_clr_ready_e%0d", i), 32'(ba.ready), 32'(i == 4));
      if (i == 1) ba.clr = 1'b1;
      if (i == 2) begin
        ba.clr = 1'b0;
        ba.wr = 1'b1; ba.wa = 2'd1; ba.wd = 32'hFFFFFFFF;
        ba.lock = 1'b1; ba.la = 2'd2;
      end
      if (i == 4) begin
        ba.wr = 1'b0; ba.lock = 1'b0;
      end
    end
    ba.ra1 = 2'd0; ba.ra2 = 2'd3;
    #1;
    chk("a_postclr_rd1_r0", ba.rd1, 32'h0);
    chk("a_postclr_busy2_r3", 32'(ba.busy2), 32'h0);
    ba.ra1 = 2'd1; ba.ra2 = 2'd2;
    #1;
    chk("a_postclr_rd1_r1", ba.rd1, 32'h0);
    chk("a_postclr_busy2_r2", 32'(ba.busy2), 32'h0);

    // ---------------- 16x8 instance ----------------
    $display("step: 16x8 sweep");
    chk("b_rst_ready", 32'(bb.ready), 32'h0);
    rst_n_b = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("b_sweep_ready_e%0d", i), 32'(bb.ready), 32'(i == 8));
    end
    bb.wr = 1'b1; bb.wa = 3'd5; bb.wd = 16'hBEEF; bb.ra1 = 3'd5; bb.ra2 = 3'd6;
    #1;
    chk("b_bypass_rd1", 32'(bb.rd1), 32'h0000BEEF);
    chk("b_bypass_rd2", 32'(bb.rd2), 32'h0);
    tick();
    bb.wr = 1'b0; bb.lock = 1'b1; bb.la = 3'd6;
    #1;
    chk("b_after_wr_rd1", 32'(bb.rd1), 32'h0000BEEF);
    tick();
    chk("b_busy2_locked", 32'(bb.busy2), 32'h1);
    chk("b_lock_err_e1", 32'(bb.lock_err), 32'h0);
    tick();
    bb.lock = 1'b0;
    #1;
    chk("b_lock_err_e2", 32'(bb.lock_err), 32'h1);

    $display("step: 16x8 clr then async reset at cnt=5");
    bb.clr = 1'b1;
    tick();
    bb.clr = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    chk("b_midsweep_ready", 32'(bb.ready), 32'h0);
    rst_n_b = 1'b0;
    #1;
    chk("b_rst_mid_ready", 32'(bb.ready), 32'h0);
    chk("b_rst_mid_lock_err", 32'(bb.lock_err), 32'h0);
    chk("b_rst_mid_busy2", 32'(bb.busy2), 32'h0);
    chk("b_rst_mid_rd1", 32'(bb.rd1), 32'h0);
    tick();
    rst_n_b = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("b_resweep_ready_e%0d", i), 32'(bb.ready), 32'(i == 8));
    end
    #1;
    chk("b_final_rd1_r5", 32'(bb.rd1), 32'h0);
    chk("b_final_busy2_r6", 32'(bb.busy2), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read scoreboarded register file for the pipelined datapath:
- Two asynchronous read ports and one synchronous write port.
- Write-to-read bypass.
- Per-register busy (pending-write) scoreboard for hazard detection.
- Sequential clear engine that zeroes storage one entry per cycle after reset or on request.

It sits between decode (read, lock) and writeback (write) and replaces the fixed 4x32 register file.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 4, number of registers; power of two, ≥2
- AW, $clog2(DEPTH), address width; derived, not overridden
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; **asynchronous, active-low**
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  WIDTH  read data (combinational)
- busy1, busy2  out  1  scoreboard bit for ra1/ra2 (combinational)
- wr  in  1  write enable
- wa  in  AW  write address
- wd  in  WIDTH  write data
- lock  in  1  mark register la as pending-write
- la  in  AW  lock address
- clr  in  1  synchronous request to re-run the clear sweep
- ready  out  1  high when in IDLE state
- lock_err  out  1  registered one-cycle pulse: lock hit an already-busy register

## Operation
- FSM states: CLEAR, IDLE.
- Reset (rst_n=0):
  - state=CLEAR, sweep counter cnt=0, all busy bits=0, lock_err=0, ready=0.
  - Storage is not reset; the sweep zeroes it.
- CLEAR:
  - Each posedge writes 0 to register[cnt] and increments cnt.
  - At the posedge where cnt==DEPTH-1, state→IDLE and cnt wraps to 0.
  - wr, lock and clr are ignored.
  - rd1/rd2 read 0 and busy1/busy2 read 0.
- IDLE, clr=1: state→CLEAR at the next posedge; all busy bits cleared at that same edge. A wr or lock in that cycle is dropped.
- IDLE reads:
  - rd1 = wd if wr && wa==ra1, else register[ra1]; rd2 likewise (write-first bypass).
- IDLE write: wr=1 stores wd into register[wa] and clears busy[wa] at the posedge.
- IDLE lock: lock=1 sets busy[la] at the posedge.
- Simultaneous lock and wr to the same address: lock wins; busy stays/becomes 1, and data is written.
- lock_err:
  - Registered; =1 for exactly one cycle after a posedge where the condition holds.
  - Condition: IDLE && !clr && lock && busy[la] && !(wr && wa==la).
  - Otherwise 0.
- busy1 = busy[ra1] && !(wr && wa==ra1) while IDLE; busy2 likewise. Bypassed data counts as available.
- Both read ports may address the same register; each is independent.
- Width rule: data is passed unmodified; no sign or zero manipulation.

## Timing
- Reset values: ready=0, lock_err=0, busy1=busy2=0, rd1=rd2=0 (CLEAR forces zero).
- Clear latency: ready rises after exactly DEPTH rising edges following rst_n deassertion or the clr edge.
  - With DEPTH=4, the sweep occupies edges 1..4; ready=1 after edge 4.
- Read latency: 0 cycles (combinational from ra, wr, wa, wd).
- Write latency: 1 edge. Without a bypass hit, new data is visible on rd the cycle after the write.
- Scoreboard: busy visible the cycle after the lock edge; cleared the cycle after the write edge. Bypass masks busy in the write cycle itself.
- lock_err asserts the cycle after the offending edge; it never lasts more than one cycle per event.
- rst_n asserted mid-sweep or mid-operation: immediate return to the reset values; the sweep restarts from 0.
- clr asserted while already in CLEAR: ignored; the sweep is not restarted.

## Test plan
- **Reset and sweep:** preload storage with 0xDEADBEEF via backdoor, pulse rst_n low, release.
  - Required: ready=0 for 4 edges, then 1; all four registers read 0x00000000.
- **Write/read and bypass:** IDLE, wr=1 wa=2 wd=0xA5A5A5A5, ra1=2, ra2=3 in the same cycle.
  - Required: rd1=0xA5A5A5A5 combinationally, rd2=0.
  - After the edge, with wr=0, rd1 is still 0xA5A5A5A5.
- **Scoreboard:** lock la=1.
  - Required: busy1=1 (ra1=1) from the next cycle.
  - Then wr wa=1 wd=0x7: busy1=0 and rd1=0x7 in the write cycle; busy stays 0 afterwards.
- **Lock conflicts:**
  - lock la=3 twice on consecutive cycles with no write: lock_err=1 for exactly one cycle after the second edge.
  - lock and wr both at address 3 while busy[3]=1: lock_err stays 0 and busy[3] stays 1.
- **clr mid-operation:** busy[0]=1, register[0]=0x55, assert clr with wr wa=0 wd=0x99.
  - Required: write dropped, busy cleared, ready=0 for 4 cycles, register[0]=0 afterwards.
- **Parametrisation and async reset:** rerun the above with WIDTH=16, DEPTH=8.
  - Required: sweep takes 8 edges.
  - Assert rst_n low mid-sweep at cnt=5: ready=0 immediately; the full 8-edge sweep restarts.
